// File: rtl/button_gesture_decoder.sv
// Button gesture decoder: turns debounced press/release events into
// single-click, double-click, long-press and auto-repeat pulses.
// Event inputs are one-cycle pulses. All pulse outputs are registered,
// so each pulse appears one cycle after the condition that qualifies it.
module button_gesture_decoder #(
    parameter int CNT_WIDTH     = 26,
    parameter int DBL_WINDOW    = 25000000,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       sw_state_i,
    input  logic       sw_down_i,
    input  logic       sw_up_i,
    output logic       click_o,
    output logic       dbl_click_o,
    output logic       long_o,
    output logic       repeat_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        LONG   = 3'd4
    } state_t;

    // Terminal counts: the counter value on the last cycle of each interval.
    localparam logic [CNT_WIDTH-1:0] DBL_LAST  = CNT_WIDTH'(DBL_WINDOW - 1);
    localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] REP_LAST  = CNT_WIDTH'(REPEAT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam longint CNT_LIMIT = longint'(1) << CNT_WIDTH;

    // Every interval must be at least 2 cycles and fit in the counter.
    if (DBL_WINDOW < 2 || longint'(DBL_WINDOW) >= CNT_LIMIT ||
        LONG_CYCLES < 2 || longint'(LONG_CYCLES) >= CNT_LIMIT ||
        REPEAT_CYCLES < 2 || longint'(REPEAT_CYCLES) >= CNT_LIMIT) begin : g_param_check
        $error("button_gesture_decoder: timing parameters out of range for CNT_WIDTH");
    end

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 click_q, click_d;
    logic                 dbl_q, dbl_d;
    logic                 long_q, long_d;
    logic                 rep_q, rep_d;
    logic                 release_c;
    logic                 down_c;
    logic                 wrap_c;

    // Next-state, counter and pulse decode. Release beats a coincident press;
    // a dropped level while held counts as a release in case sw_up_i was lost.
    always_comb begin
        state_d   = state_q;
        click_d   = 1'b0;
        dbl_d     = 1'b0;
        long_d    = 1'b0;
        rep_d     = 1'b0;
        wrap_c    = 1'b0;
        release_c = sw_up_i |
                    (~sw_state_i & ((state_q == PRESS1) || (state_q == PRESS2) ||
                                    (state_q == LONG)));
        down_c    = sw_down_i & ~release_c;

        case (state_q)
            IDLE: begin
                if (down_c) state_d = PRESS1;
            end
            PRESS1: begin
                if (release_c) begin
                    state_d = WAIT2;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                end
            end
            WAIT2: begin
                if (down_c) begin
                    state_d = PRESS2;
                end else if (cnt_q == DBL_LAST) begin
                    state_d = IDLE;
                    click_d = 1'b1;
                end
            end
            PRESS2: begin
                if (release_c) begin
                    state_d = IDLE;
                    dbl_d   = 1'b1;
                end
            end
            LONG: begin
                if (release_c) begin
                    state_d = IDLE;
                end else if (cnt_q == REP_LAST) begin
                    rep_d  = 1'b1;
                    wrap_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_d != state_q) || wrap_c) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, counter and registered pulse outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            click_q <= 1'b0;
            dbl_q   <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            click_q <= click_d;
            dbl_q   <= dbl_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
        end
    end

    assign click_o     = click_q;
    assign dbl_click_o = dbl_q;
    assign long_o      = long_q;
    assign repeat_o    = rep_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Bench for button_gesture_decoder with short timing parameters.
// Each expected pulse is queued as {pulse code, cycle}; the monitor pops one
// entry per observed pulse. Pulse code bits are {click, dbl, long, repeat}.
module tb_button_gesture_decoder;

    localparam logic [3:0] P_CLICK = 4'b1000;
    localparam logic [3:0] P_DBL   = 4'b0100;
    localparam logic [3:0] P_LONG  = 4'b0010;
    localparam logic [3:0] P_REP   = 4'b0001;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       sw_state_i = 1'b0;
    logic       sw_down_i = 1'b0;
    logic       sw_up_i = 1'b0;
    logic       click_o, dbl_click_o, long_o, repeat_o;
    logic [2:0] state_o;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic [35:0] exp_q[$];

    button_gesture_decoder #(
        .CNT_WIDTH(8),
        .DBL_WINDOW(8),
        .LONG_CYCLES(16),
        .REPEAT_CYCLES(4)
    ) dut (
        .clk(clk),
        .arst_n(arst_n),
        .sw_state_i(sw_state_i),
        .sw_down_i(sw_down_i),
        .sw_up_i(sw_up_i),
        .click_o(click_o),
        .dbl_click_o(dbl_click_o),
        .long_o(long_o),
        .repeat_o(repeat_o),
        .state_o(state_o)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, got cycle %0d, required finish", cyc);
        $fatal(1, "watchdog");
    end

    // monitor: every pulse must match the head of the expected queue
    always @(negedge clk) begin
        logic [3:0]  pulses;
        logic [35:0] e;
        pulses = {click_o, dbl_click_o, long_o, repeat_o};
        if (pulses != 4'b0000) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got code %b at cycle %0d, required none", pulses, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e != {pulses, 32'(cyc)}) begin
                    errors++;
                    $display("FAIL pulse: got code %b at cycle %0d, required code %b at cycle %0d",
                             pulses, cyc, e[35:32], e[31:0]);
                end
            end
        end
    end

    // advance to cycle t, clearing the one-cycle pulse inputs on each new cycle
    task automatic step_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
            sw_down_i = 1'b0;
            sw_up_i   = 1'b0;
        end
    endtask

    task automatic expect_pulse(input logic [3:0] code, input int t);
        exp_q.push_back({code, 32'(t)});
    endtask

    task automatic check_state(input string name, input logic [2:0] exp);
        checks++;
        if (state_o !== exp) begin
            errors++;
            $display("FAIL %s: got state %0d, required %0d", name, state_o, exp);
        end
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if ({click_o, dbl_click_o, long_o, repeat_o, state_o} !== 7'b0) begin
            errors++;
            $display("FAIL %s: got pulses %b state %0d, required all zero", name,
                     {click_o, dbl_click_o, long_o, repeat_o}, state_o);
        end
    endtask

    initial begin
        int t;
        // reset
        #3;
        check_quiet("reset_outputs");
        #20;
        arst_n = 1'b1;
        step_to(4);
        check_state("idle_after_reset", 3'd0);

        // single click
        t = cyc + 2;
        step_to(t);     sw_down_i = 1'b1; sw_state_i = 1'b1;
        expect_pulse(P_CLICK, t + 12);
        step_to(t + 3); sw_up_i = 1'b1; sw_state_i = 1'b0;
        step_to(t + 5);  check_state("single_wait2", 3'd2);
        step_to(t + 14); check_state("single_idle", 3'd0);

        // double click
        t = cyc + 3;
        step_to(t);     sw_down_i = 1'b1; sw_state_i = 1'b1;
        expect_pulse(P_DBL, t + 10);
        step_to(t + 3); sw_up_i = 1'b1; sw_state_i = 1'b0;
        step_to(t + 6); sw_down_i = 1'b1; sw_state_i = 1'b1;
        step_to(t + 8); check_state("double_press2", 3'd3);
        step_to(t + 9); sw_up_i = 1'b1; sw_state_i = 1'b0;
        step_to(t + 20); check_state("double_idle", 3'd0);

        // long press with auto-repeat
        t = cyc + 3;
        step_to(t);     sw_down_i = 1'b1; sw_state_i = 1'b1;
        expect_pulse(P_LONG, t + 17);
        expect_pulse(P_REP, t + 21);
        expect_pulse(P_REP, t + 25);
        expect_pulse(P_REP, t + 29);
        step_to(t + 16); check_state("long_press1", 3'd1);
        step_to(t + 20); check_state("long_state", 3'd4);
        step_to(t + 30); sw_up_i = 1'b1; sw_state_i = 1'b0;
        step_to(t + 31); check_state("long_release_idle", 3'd0);
        step_to(t + 45); check_state("long_no_click", 3'd0);

        // release on the long-press boundary cycle wins
        t = cyc + 3;
        step_to(t);      sw_down_i = 1'b1; sw_state_i = 1'b1;
        expect_pulse(P_CLICK, t + 25);
        step_to(t + 16); sw_up_i = 1'b1; sw_state_i = 1'b0;
        step_to(t + 17); check_state("boundary_wait2", 3'd2);
        step_to(t + 30);

        // missed release pulse: level drop alone acts as release
        t = cyc + 3;
        step_to(t);     sw_down_i = 1'b1; sw_state_i = 1'b1;
        expect_pulse(P_CLICK, t + 13);
        step_to(t + 4); sw_state_i = 1'b0;
        step_to(t + 5); check_state("missed_wait2", 3'd2);
        step_to(t + 20);

        // second press on the WAIT2 timeout cycle wins
        t = cyc + 3;
        step_to(t);      sw_down_i = 1'b1; sw_state_i = 1'b1;
        expect_pulse(P_DBL, t + 15);
        step_to(t + 3);  sw_up_i = 1'b1; sw_state_i = 1'b0;
        step_to(t + 11); sw_down_i = 1'b1; sw_state_i = 1'b1;
        step_to(t + 12); check_state("timeout_press2", 3'd3);
        step_to(t + 14); sw_up_i = 1'b1; sw_state_i = 1'b0;
        step_to(t + 25);

        // coincident up and down in WAIT2: the press is ignored
        t = cyc + 3;
        step_to(t);     sw_down_i = 1'b1; sw_state_i = 1'b1;
        expect_pulse(P_CLICK, t + 12);
        step_to(t + 3); sw_up_i = 1'b1; sw_state_i = 1'b0;
        step_to(t + 6); sw_up_i = 1'b1; sw_down_i = 1'b1;
        step_to(t + 7); check_state("coincident_wait2", 3'd2);
        step_to(t + 20);

        // lone release pulse in IDLE is ignored
        t = cyc + 2;
        step_to(t);     sw_up_i = 1'b1;
        step_to(t + 2); check_state("idle_up_ignored", 3'd0);

        // reset mid-gesture, level still high afterwards
        t = cyc + 3;
        step_to(t);     sw_down_i = 1'b1; sw_state_i = 1'b1;
        step_to(t + 5); arst_n = 1'b0;
        #1;
        check_quiet("reset_mid_gesture");
        step_to(t + 7); arst_n = 1'b1;
        step_to(t + 47); check_state("reset_stays_idle", 3'd0);
        sw_up_i = 1'b1; sw_state_i = 1'b0;
        step_to(t + 60); check_state("reset_final_idle", 3'd0);

        // every queued pulse must have been seen
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses: got %0d unconsumed entries, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_gesture_decoder.md
BUTTON_GESTURE_DECODER -- requirements
Module: button_gesture_decoder

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 26: width of the internal timing counter.
REQ-002 The block SHALL have parameter DBL_WINDOW, default 25000000: the release-to-press window, in clk cycles, for a double click (250 ms at 100 MHz).
REQ-003 The block SHALL have parameter LONG_CYCLES, default 50000000: the hold time, in clk cycles, that qualifies a long press.
REQ-004 The block SHALL have parameter REPEAT_CYCLES, default 10000000: the auto-repeat period, in clk cycles, while a long press is held.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port arst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port sw_state_i, input, 1 bit: debounced level, 1 = pressed.
REQ-008 The block SHALL have port sw_down_i, input, 1 bit: one-cycle press pulse from the debouncer.
REQ-009 The block SHALL have port sw_up_i, input, 1 bit: one-cycle release pulse from the debouncer.
REQ-010 The block SHALL have port click_o, output, 1 bit: one-cycle single-click pulse.
REQ-011 The block SHALL have port dbl_click_o, output, 1 bit: one-cycle double-click pulse.
REQ-012 The block SHALL have port long_o, output, 1 bit: one-cycle long-press-start pulse.
REQ-013 The block SHALL have port repeat_o, output, 1 bit: one-cycle auto-repeat pulse.
REQ-014 The block SHALL have port state_o, output, 3 bits: current FSM state encoding, for debug.

Function
REQ-015 The FSM SHALL have states IDLE=0, PRESS1=1, WAIT2=2, PRESS2=3, LONG=4; encodings 5-7 SHALL go to IDLE on the next cycle.
REQ-016 The counter SHALL clear to 0 on every state transition and increment by 1 each cycle the state is unchanged, saturating at all-ones.
REQ-017 A release condition SHALL be sw_up_i=1, or sw_state_i=0 while in PRESS1, PRESS2 or LONG (missed-pulse recovery).
REQ-018 When release and sw_down_i are both 1 in the same cycle, release SHALL take priority and sw_down_i SHALL be ignored.
REQ-019 IDLE: sw_down_i -> PRESS1; sw_up_i alone SHALL be ignored.
REQ-020 PRESS1: release -> WAIT2; otherwise, when counter = LONG_CYCLES-1, the FSM SHALL go to LONG and pulse long_o.
REQ-021 WAIT2: sw_down_i -> PRESS2; otherwise, when counter = DBL_WINDOW-1, the FSM SHALL go to IDLE and pulse click_o.
REQ-022 PRESS2: release -> IDLE with a dbl_click_o pulse; there SHALL be no long detection in PRESS2.
REQ-023 LONG: when counter = REPEAT_CYCLES-1, the block SHALL pulse repeat_o and wrap the counter to 0; release -> IDLE with no click pulse.
REQ-024 All outputs SHALL be registered, giving 1-cycle latency: a pulse SHALL be high in the cycle after the qualifying condition.
REQ-025 No more than one of click_o, dbl_click_o, long_o, repeat_o SHALL be high in any cycle.
REQ-026 A release in the same cycle that PRESS1's counter reaches LONG_CYCLES-1 SHALL win, going to WAIT2 with no long_o.
REQ-027 sw_down_i in the same cycle that WAIT2 times out SHALL win, going to PRESS2 with no click_o.
REQ-028 The parameters SHALL satisfy 2 <= DBL_WINDOW, LONG_CYCLES, REPEAT_CYCLES < 2^CNT_WIDTH; a violation SHALL be caught by an elaboration-time check.

Reset
REQ-029 While arst_n=0, the FSM SHALL be IDLE, the counter 0, all pulse outputs 0 and state_o=0, applied asynchronously.
REQ-030 Reset asserted mid-gesture SHALL discard the gesture; no pulse SHALL be emitted after deassertion until a new sw_down_i arrives.
REQ-031 After reset deassertion with sw_state_i=1 and no sw_down_i, the FSM SHALL stay IDLE.

Verification (DBL_WINDOW=8, LONG_CYCLES=16, REPEAT_CYCLES=4)
REQ-032 Single click: sw_down_i at T, sw_up_i at T+3 -> click_o high only at T+12; no other pulses.
REQ-033 Double click: down at T, up at T+3, down at T+6, up at T+9 -> dbl_click_o high only at T+10; click_o never high.
REQ-034 Long press with repeat: down at T, level held until T+30 -> long_o at T+17 and repeat_o at T+21, T+25 and T+29; after up at T+30 the FSM is IDLE with no click.
REQ-035 Boundary: down at T, up at T+16 -> WAIT2 with no long_o; click_o at T+25.
REQ-036 Reset mid-gesture: down at T, arst_n low T+5..T+6 -> outputs 0 from T+5 and no pulse for 40 cycles.
REQ-037 Missed pulse: down at T, sw_state_i drops at T+4 with no sw_up_i -> behaves as release: click_o at T+13.
